// File: rtl/pdp8_pkg.sv
// Shared PDP-8 front-end types: memory bus-owner encoding and arbiter defaults.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif

package pdp8_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH_RD = 2'd1,
    EXEC_RD  = 2'd2,
    EXEC_WR  = 2'd3
  } mem_owner_e;

  localparam int MAX_WAIT_DEF = 3;

endpackage

// File: rtl/pdp_mem_arbiter_if.sv
// Bundle of the fetch, exec and memory_pdp signals around the arbiter.
// The slave view belongs to the arbiter; the master view belongs to requesters and memory.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif

interface pdp_mem_arbiter_if #(
  parameter int ADDR_WIDTH = `ADDR_WIDTH,
  parameter int DATA_WIDTH = `DATA_WIDTH
);
  logic                  ifu_rd_req;
  logic [ADDR_WIDTH-1:0] ifu_rd_addr;
  logic [DATA_WIDTH-1:0] ifu_rd_data;
  logic                  ifu_rd_valid;
  logic                  ifu_busy;

  logic                  exec_rd_req;
  logic [ADDR_WIDTH-1:0] exec_rd_addr;
  logic                  exec_wr_req;
  logic [ADDR_WIDTH-1:0] exec_wr_addr;
  logic [DATA_WIDTH-1:0] exec_wr_data;
  logic [DATA_WIDTH-1:0] exec_rd_data;
  logic                  exec_rd_valid;
  logic                  exec_wr_done;
  logic                  exec_busy;

  logic                  mem_rd_req;
  logic [ADDR_WIDTH-1:0] mem_rd_addr;
  logic                  mem_wr_req;
  logic [ADDR_WIDTH-1:0] mem_wr_addr;
  logic [DATA_WIDTH-1:0] mem_wr_data;
  logic [DATA_WIDTH-1:0] mem_rd_data;

  logic                  proto_err;

  modport slave (
    input  ifu_rd_req, ifu_rd_addr,
    input  exec_rd_req, exec_rd_addr, exec_wr_req, exec_wr_addr, exec_wr_data,
    input  mem_rd_data,
    output ifu_rd_data, ifu_rd_valid, ifu_busy,
    output exec_rd_data, exec_rd_valid, exec_wr_done, exec_busy,
    output mem_rd_req, mem_rd_addr, mem_wr_req, mem_wr_addr, mem_wr_data,
    output proto_err
  );

  modport master (
    output ifu_rd_req, ifu_rd_addr,
    output exec_rd_req, exec_rd_addr, exec_wr_req, exec_wr_addr, exec_wr_data,
    output mem_rd_data,
    input  ifu_rd_data, ifu_rd_valid, ifu_busy,
    input  exec_rd_data, exec_rd_valid, exec_wr_done, exec_busy,
    input  mem_rd_req, mem_rd_addr, mem_wr_req, mem_wr_addr, mem_wr_data,
    input  proto_err
  );
endinterface

// File: rtl/pdp_req_slot.sv
// One-entry request holding slot. Outputs show the slot as it looks after this
// cycle's load, so an op can be loaded and issued on the same edge.
module pdp_req_slot
  import pdp8_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_load,
  input  mem_owner_e            i_op,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_clear,
  output logic                  o_pending,
  output mem_owner_e            o_op,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic                  r_pending;
  mem_owner_e            r_op;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;

  assign o_pending = r_pending | i_load;
  assign o_op      = i_load ? i_op   : r_op;
  assign o_addr    = i_load ? i_addr : r_addr;
  assign o_data    = i_load ? i_data : r_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending <= 1'b0;
      r_op      <= IDLE;
      r_addr    <= '0;
      r_data    <= '0;
    end else begin
      r_pending <= o_pending & ~i_clear;
      if (i_load) begin
        r_op   <= i_op;
        r_addr <= i_addr;
        r_data <= i_data;
      end
    end
  end

endmodule

// File: rtl/pdp_mem_arbiter.sv
// Shares memory_pdp between instruction fetch and exec: exec wins by default,
// but a fetch that has lost MAX_WAIT times in a row is forced through.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif

module pdp_mem_arbiter
  import pdp8_pkg::*;
#(
  parameter int ADDR_WIDTH = `ADDR_WIDTH,
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int MAX_WAIT   = MAX_WAIT_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  pdp_mem_arbiter_if.slave bus
);

  localparam int             WCW      = $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(MAX_WAIT);

  mem_owner_e            r_owner, r_rd_owner, w_owner_nx;
  logic [WCW-1:0]        r_wait_cnt, w_wait_nx;
  logic                  r_ifu_busy, r_exec_busy, r_proto_err;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_data;

  logic                  w_ifu_load, w_exec_any, w_exec_load, w_proto_viol;
  mem_owner_e            w_exec_req_op, w_fetch_op, w_exec_op;
  logic [ADDR_WIDTH-1:0] w_exec_req_addr, w_fetch_addr, w_exec_addr;
  logic [DATA_WIDTH-1:0] w_fetch_data, w_exec_data;
  logic                  w_fetch_pend, w_exec_pend, w_grant_fetch, w_grant_exec;
  logic                  w_ifu_busy_nx, w_exec_busy_nx;

  assign w_ifu_load  = bus.ifu_rd_req & ~r_ifu_busy;
  assign w_exec_any  = bus.exec_rd_req | bus.exec_wr_req;
  assign w_exec_load = w_exec_any & ~r_exec_busy;
  // A read colliding with a write is dropped; the write survives.
  assign w_exec_req_op   = bus.exec_wr_req ? EXEC_WR : EXEC_RD;
  assign w_exec_req_addr = bus.exec_wr_req ? bus.exec_wr_addr : bus.exec_rd_addr;
  assign w_proto_viol    = (bus.ifu_rd_req & r_ifu_busy) | (w_exec_any & r_exec_busy) |
                           (bus.exec_rd_req & bus.exec_wr_req);

  pdp_req_slot #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_ifu_slot (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_load   (w_ifu_load),
    .i_op     (FETCH_RD),
    .i_addr   (bus.ifu_rd_addr),
    .i_data   ('0),
    .i_clear  (w_grant_fetch),
    .o_pending(w_fetch_pend),
    .o_op     (w_fetch_op),
    .o_addr   (w_fetch_addr),
    .o_data   (w_fetch_data)
  );

  pdp_req_slot #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_exec_slot (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_load   (w_exec_load),
    .i_op     (w_exec_req_op),
    .i_addr   (w_exec_req_addr),
    .i_data   (bus.exec_wr_data),
    .i_clear  (w_grant_exec),
    .o_pending(w_exec_pend),
    .o_op     (w_exec_op),
    .o_addr   (w_exec_addr),
    .o_data   (w_exec_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_owner    <= IDLE;
      r_rd_owner <= IDLE;
    end else begin
      r_owner    <= w_owner_nx;
      r_rd_owner <= r_owner;
    end
  end

  always_comb begin
    w_owner_nx    = IDLE;
    w_grant_fetch = 1'b0;
    w_grant_exec  = 1'b0;
    if (w_fetch_pend && (r_wait_cnt == WAIT_MAX)) begin
      w_owner_nx    = w_fetch_op;
      w_grant_fetch = 1'b1;
    end else if (w_exec_pend) begin
      w_owner_nx    = w_exec_op;
      w_grant_exec  = 1'b1;
    end else if (w_fetch_pend) begin
      w_owner_nx    = w_fetch_op;
      w_grant_fetch = 1'b1;
    end
  end

  always_comb begin
    bus.mem_rd_req    = (r_owner == FETCH_RD) || (r_owner == EXEC_RD);
    bus.mem_wr_req    = (r_owner == EXEC_WR);
    bus.exec_wr_done  = (r_owner == EXEC_WR);
    bus.ifu_rd_valid  = (r_rd_owner == FETCH_RD);
    bus.exec_rd_valid = (r_rd_owner == EXEC_RD);
  end

  assign bus.mem_rd_addr  = r_mem_addr;
  assign bus.mem_wr_addr  = r_mem_addr;
  assign bus.mem_wr_data  = r_mem_data;
  assign bus.ifu_rd_data  = bus.mem_rd_data;
  assign bus.exec_rd_data = bus.mem_rd_data;
  assign bus.ifu_busy     = r_ifu_busy;
  assign bus.exec_busy    = r_exec_busy;
  assign bus.proto_err    = r_proto_err;

  always_comb begin
    w_wait_nx = r_wait_cnt;
    if (w_grant_fetch || !w_fetch_pend) begin
      w_wait_nx = '0;
    end else if (w_grant_exec && (r_wait_cnt != WAIT_MAX)) begin
      w_wait_nx = r_wait_cnt + 1'b1;
    end
  end

  // Busy spans the pending slot, the issue cycle and, for reads, the return cycle.
  assign w_ifu_busy_nx  = w_fetch_pend | (r_owner == FETCH_RD);
  assign w_exec_busy_nx = w_exec_pend  | (r_owner == EXEC_RD);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wait_cnt  <= '0;
      r_ifu_busy  <= 1'b0;
      r_exec_busy <= 1'b0;
      r_proto_err <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_data  <= '0;
    end else begin
      r_wait_cnt  <= w_wait_nx;
      r_ifu_busy  <= w_ifu_busy_nx;
      r_exec_busy <= w_exec_busy_nx;
      r_proto_err <= r_proto_err | w_proto_viol;
      if (w_grant_fetch) begin
        r_mem_addr <= w_fetch_addr;
        r_mem_data <= w_fetch_data;
      end else if (w_grant_exec) begin
        r_mem_addr <= w_exec_addr;
        r_mem_data <= w_exec_data;
      end
    end
  end

endmodule

// File: tb/tb_pdp_mem_arbiter.sv
// Bench for pdp_mem_arbiter: directed scenarios plus random traffic against a
// transaction-level model of slots, priority and starvation limit.
module tb_pdp_mem_arbiter;

  localparam int AW = 12;
  localparam int DW = 12;
  localparam int MW = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  pdp_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  pdp_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MW)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [DW-1:0] mem [0:4095];

  // Model state: pending requests, fetch losses, op issued in the current cycle.
  bit          m_fp, m_ep, m_ewr;
  logic [11:0] m_fa, m_ea, m_ed, m_last_addr;
  int          m_loss, m_last;
  // Model's expected outputs for the current cycle.
  bit          e_mem_rd, e_mem_wr, e_ifu_v, e_exec_v, e_wr_done, e_ifu_busy, e_exec_busy, e_perr;
  logic [11:0] e_addr, e_wdata, e_rd_addr;

  function automatic void model_reset();
    m_fp = 0; m_ep = 0; m_ewr = 0; m_fa = 0; m_ea = 0; m_ed = 0;
    m_loss = 0; m_last = 0; m_last_addr = 0;
    e_mem_rd = 0; e_mem_wr = 0; e_ifu_v = 0; e_exec_v = 0; e_wr_done = 0;
    e_ifu_busy = 0; e_exec_busy = 0; e_perr = 0;
    e_addr = 0; e_wdata = 0; e_rd_addr = 0;
  endfunction

  // Advances the model by one cycle given that cycle's requests (1=fetch, 2=exec rd, 3=exec wr).
  function automatic void model_step(bit ir, logic [11:0] ia, bit er, bit ew,
                                     logic [11:0] ea, logic [11:0] ed);
    int iss, prev;
    logic [11:0] prev_addr;
    if ((ir && e_ifu_busy) || ((er || ew) && e_exec_busy) || (er && ew)) e_perr = 1;
    if (ir && !e_ifu_busy) begin m_fp = 1; m_fa = ia; end
    if ((er || ew) && !e_exec_busy) begin m_ep = 1; m_ewr = ew; m_ea = ea; m_ed = ed; end
    prev = m_last;
    prev_addr = m_last_addr;
    iss = 0;
    if (m_fp && m_loss >= MW) iss = 1;
    else if (m_ep)            iss = m_ewr ? 3 : 2;
    else if (m_fp)            iss = 1;
    if (iss == 1) begin
      m_fp = 0; m_loss = 0; e_addr = m_fa;
    end else if (iss >= 2) begin
      m_ep = 0; e_addr = m_ea;
      if (iss == 3) e_wdata = m_ed;
      m_loss = m_fp ? ((m_loss + 1 > MW) ? MW : m_loss + 1) : 0;
    end else begin
      m_loss = 0;
    end
    e_mem_rd    = (iss == 1) || (iss == 2);
    e_mem_wr    = (iss == 3);
    e_wr_done   = (iss == 3);
    e_ifu_v     = (prev == 1);
    e_exec_v    = (prev == 2);
    e_rd_addr   = prev_addr;
    e_ifu_busy  = m_fp || (iss == 1) || (prev == 1);
    e_exec_busy = m_ep || (iss >= 2) || (prev == 2);
    m_last = iss;
    if (iss != 0) m_last_addr = e_addr;
  endfunction

  // Memory model: writes land, reads return data in the following cycle.
  task automatic respond();
    if (bus.mem_wr_req === 1'b1) mem[bus.mem_wr_addr] = bus.mem_wr_data;
    if (bus.mem_rd_req === 1'b1) bus.mem_rd_data = mem[bus.mem_rd_addr];
    else                         bus.mem_rd_data = DW'($urandom);
  endtask

  task automatic step(input bit ir, input logic [11:0] ia, input bit er, input bit ew,
                      input logic [11:0] ea, input logic [11:0] ed);
    respond();
    bus.ifu_rd_req   = ir;  bus.ifu_rd_addr  = ia;
    bus.exec_rd_req  = er;  bus.exec_rd_addr = ea;
    bus.exec_wr_req  = ew;  bus.exec_wr_addr = ea;  bus.exec_wr_data = ed;
    model_step(ir, ia, er, ew, ea, ed);
    @(negedge clk);
    cyc++;
    bus.ifu_rd_req = 0; bus.exec_rd_req = 0; bus.exec_wr_req = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset_n = 0;
    bus.ifu_rd_req = 0; bus.exec_rd_req = 0; bus.exec_wr_req = 0;
    bus.ifu_rd_addr = 0; bus.exec_rd_addr = 0; bus.exec_wr_addr = 0; bus.exec_wr_data = 0;
    bus.mem_rd_data = 0;
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1;
  endtask

  function automatic logic [7:0] ctrl();
    return {bus.mem_rd_req, bus.mem_wr_req, bus.ifu_rd_valid, bus.exec_rd_valid,
            bus.exec_wr_done, bus.ifu_busy, bus.exec_busy, bus.proto_err};
  endfunction

  function automatic logic [59:0] datapath();
    return {bus.mem_rd_addr, bus.mem_wr_addr, bus.mem_wr_data, bus.ifu_rd_data, bus.exec_rd_data};
  endfunction

  task automatic test_reset();
    do_reset();
    checks++;
    if (ctrl() !== 8'h00) begin
      failures++; $display("FAIL reset_ctrl: got %b expected %b", ctrl(), 8'h00);
    end
    checks++;
    if (datapath() !== 60'd0) begin
      failures++; $display("FAIL reset_data: got %h expected 0", datapath());
    end
    idle(1);
    checks++;
    if (ctrl() !== 8'h00) begin
      failures++; $display("FAIL reset_idle_ctrl: got %b expected %b", ctrl(), 8'h00);
    end
  endtask

  task automatic single_fetch(input string tag);
    step(1, 12'o0200, 0, 0, 0, 0);
    checks++;
    if ({bus.mem_rd_req, bus.mem_wr_req, bus.ifu_busy, bus.ifu_rd_valid} !== 4'b1010 ||
        bus.mem_rd_addr !== 12'o0200) begin
      failures++;
      $display("FAIL %s_issue: got rd=%b wr=%b busy=%b v=%b addr=%o expected 1 0 1 0 0200",
               tag, bus.mem_rd_req, bus.mem_wr_req, bus.ifu_busy, bus.ifu_rd_valid, bus.mem_rd_addr);
    end
    idle(1);
    checks++;
    if ({bus.ifu_rd_valid, bus.exec_rd_valid, bus.mem_rd_req, bus.ifu_busy} !== 4'b1001 ||
        bus.ifu_rd_data !== 12'o7300) begin
      failures++;
      $display("FAIL %s_return: got v=%b ev=%b rd=%b busy=%b data=%o expected 1 0 0 1 7300",
               tag, bus.ifu_rd_valid, bus.exec_rd_valid, bus.mem_rd_req, bus.ifu_busy, bus.ifu_rd_data);
    end
    idle(1);
    checks++;
    if ({bus.ifu_rd_valid, bus.ifu_busy} !== 2'b00) begin
      failures++;
      $display("FAIL %s_done: got v=%b busy=%b expected 0 0", tag, bus.ifu_rd_valid, bus.ifu_busy);
    end
  endtask

  task automatic test_fetch();
    do_reset();
    single_fetch("fetch");
  endtask

  task automatic test_exec_priority();
    do_reset();
    step(1, 12'o0200, 0, 1, 12'o0050, 12'o1234);
    checks++;
    if ({bus.mem_wr_req, bus.exec_wr_done, bus.mem_rd_req} !== 3'b110 ||
        bus.mem_wr_addr !== 12'o0050 || bus.mem_wr_data !== 12'o1234) begin
      failures++;
      $display("FAIL prio_write: got wr=%b done=%b rd=%b addr=%o data=%o expected 1 1 0 0050 1234",
               bus.mem_wr_req, bus.exec_wr_done, bus.mem_rd_req, bus.mem_wr_addr, bus.mem_wr_data);
    end
    idle(1);
    checks++;
    if ({bus.mem_rd_req, bus.mem_wr_req, bus.exec_wr_done} !== 3'b100 ||
        bus.mem_rd_addr !== 12'o0200) begin
      failures++;
      $display("FAIL prio_fetch: got rd=%b wr=%b done=%b addr=%o expected 1 0 0 0200",
               bus.mem_rd_req, bus.mem_wr_req, bus.exec_wr_done, bus.mem_rd_addr);
    end
    idle(1);
    checks++;
    if (bus.ifu_rd_valid !== 1'b1 || bus.ifu_rd_data !== 12'o7300) begin
      failures++;
      $display("FAIL prio_return: got v=%b data=%o expected 1 7300", bus.ifu_rd_valid, bus.ifu_rd_data);
    end
    idle(2);
  endtask

  task automatic test_starvation();
    int  pulse_cyc, grants;
    bit  fpend;
    do_reset();
    fpend = 0; pulse_cyc = 0; grants = 0;
    for (int i = 0; i < 40; i++) begin
      bit ir, er;
      if (fpend && bus.mem_rd_req === 1'b1 && bus.mem_rd_addr === 12'o0400) begin
        checks++;
        if (cyc - pulse_cyc > MW + 1) begin
          failures++;
          $display("FAIL starve_delay: got %0d cycles expected <= %0d", cyc - pulse_cyc, MW + 1);
        end
        fpend = 0; grants++;
      end
      ir = (bus.ifu_busy === 1'b0) && (i < 32);
      er = (bus.exec_busy === 1'b0) && (i < 32);
      if (ir) begin pulse_cyc = cyc; fpend = 1; end
      step(ir, 12'o0400, er, 0, 12'o0100 + 12'(i), 0);
    end
    checks++;
    if (fpend || grants < 4) begin
      failures++;
      $display("FAIL starve_grants: got %0d grants pending=%0d expected >=4 pending=0", grants, fpend);
    end
    idle(2);
    checks++;
    if (dut.r_wait_cnt !== 2'd0) begin
      failures++; $display("FAIL starve_wait_cnt: got %0d expected 0", dut.r_wait_cnt);
    end
  endtask

  task automatic test_proto_err();
    do_reset();
    step(0, 0, 1, 1, 12'o0060, 12'o4321);
    checks++;
    if ({bus.mem_rd_req, bus.mem_wr_req, bus.proto_err} !== 3'b011 || bus.mem_wr_addr !== 12'o0060) begin
      failures++;
      $display("FAIL proto_dual: got rd=%b wr=%b err=%b addr=%o expected 0 1 1 0060",
               bus.mem_rd_req, bus.mem_wr_req, bus.proto_err, bus.mem_wr_addr);
    end
    idle(1);
    checks++;
    if ({bus.exec_rd_valid, bus.mem_rd_req, bus.proto_err} !== 3'b001) begin
      failures++;
      $display("FAIL proto_no_read: got ev=%b rd=%b err=%b expected 0 0 1",
               bus.exec_rd_valid, bus.mem_rd_req, bus.proto_err);
    end
    idle(3);
    checks++;
    if (bus.proto_err !== 1'b1) begin
      failures++; $display("FAIL proto_sticky: got %b expected 1", bus.proto_err);
    end
    do_reset();
    step(1, 12'o0200, 0, 0, 0, 0);
    checks++;
    if ({bus.ifu_busy, bus.proto_err} !== 2'b10) begin
      failures++;
      $display("FAIL proto_clean: got busy=%b err=%b expected 1 0", bus.ifu_busy, bus.proto_err);
    end
    step(1, 12'o0210, 0, 0, 0, 0);
    checks++;
    if ({bus.proto_err, bus.mem_rd_req} !== 2'b10) begin
      failures++;
      $display("FAIL proto_ifu_busy: got err=%b rd=%b expected 1 0", bus.proto_err, bus.mem_rd_req);
    end
    idle(3);
  endtask

  task automatic test_reset_inflight();
    do_reset();
    step(1, 12'o0200, 0, 0, 0, 0);
    checks++;
    if (bus.mem_rd_req !== 1'b1) begin
      failures++; $display("FAIL inflight_issue: got %b expected 1", bus.mem_rd_req);
    end
    reset_n = 0;
    bus.mem_rd_data = 0;
    #1;
    checks++;
    if (ctrl() !== 8'h00 || datapath() !== 60'd0) begin
      failures++; $display("FAIL inflight_reset: got %b %h expected all 0", ctrl(), datapath());
    end
    @(negedge clk);
    cyc++;
    checks++;
    if ({bus.ifu_rd_valid, bus.exec_rd_valid} !== 2'b00) begin
      failures++;
      $display("FAIL inflight_valid: got %b %b expected 0 0", bus.ifu_rd_valid, bus.exec_rd_valid);
    end
    reset_n = 1;
    model_reset();
    single_fetch("after_reset");
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 500; i++) begin
      bit ir, er, ew;
      int r;
      checks++;
      if (ctrl() !== {e_mem_rd, e_mem_wr, e_ifu_v, e_exec_v, e_wr_done, e_ifu_busy, e_exec_busy, e_perr}) begin
        failures++;
        $display("FAIL rand_ctrl[%0d]: got %b expected %b", i, ctrl(),
                 {e_mem_rd, e_mem_wr, e_ifu_v, e_exec_v, e_wr_done, e_ifu_busy, e_exec_busy, e_perr});
      end
      if (e_mem_rd) begin
        checks++;
        if (bus.mem_rd_addr !== e_addr) begin
          failures++; $display("FAIL rand_rd_addr[%0d]: got %o expected %o", i, bus.mem_rd_addr, e_addr);
        end
      end
      if (e_mem_wr) begin
        checks++;
        if (bus.mem_wr_addr !== e_addr || bus.mem_wr_data !== e_wdata) begin
          failures++;
          $display("FAIL rand_wr[%0d]: got %o/%o expected %o/%o", i, bus.mem_wr_addr, bus.mem_wr_data, e_addr, e_wdata);
        end
      end
      if (e_ifu_v) begin
        checks++;
        if (bus.ifu_rd_data !== mem[e_rd_addr]) begin
          failures++; $display("FAIL rand_ifu_data[%0d]: got %o expected %o", i, bus.ifu_rd_data, mem[e_rd_addr]);
        end
      end
      if (e_exec_v) begin
        checks++;
        if (bus.exec_rd_data !== mem[e_rd_addr]) begin
          failures++; $display("FAIL rand_exec_data[%0d]: got %o expected %o", i, bus.exec_rd_data, mem[e_rd_addr]);
        end
      end
      ir = ($urandom_range(0, 2) == 0) && (bus.ifu_busy === 1'b0 || $urandom_range(0, 15) == 0);
      r  = $urandom_range(0, 7);
      er = (r < 2) || (r == 7 && $urandom_range(0, 7) == 0);
      ew = (r == 2) || (r == 3) || (r == 7 && er);
      if (bus.exec_busy === 1'b1 && $urandom_range(0, 15) != 0) begin er = 0; ew = 0; end
      step(ir, 12'($urandom), er, ew, 12'($urandom), 12'($urandom));
    end
  endtask

  initial begin
    bus.ifu_rd_req = 0; bus.exec_rd_req = 0; bus.exec_wr_req = 0;
    bus.ifu_rd_addr = 0; bus.exec_rd_addr = 0; bus.exec_wr_addr = 0; bus.exec_wr_data = 0;
    bus.mem_rd_data = 0;
    for (int i = 0; i < 4096; i++) mem[i] = DW'($urandom);
    mem[12'o0200] = 12'o7300;
    model_reset();
    test_reset();
    test_fetch();
    test_exec_priority();
    test_starvation();
    test_proto_err();
    test_reset_inflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
